// File: rtl/hilo_pkg.sv
// Shared types and helpers for the HI/LO result unit.
package hilo_pkg;

    typedef enum logic {
        HILO_IDLE = 1'b0,
        HILO_WAIT = 1'b1
    } hilo_state_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hilo_src_mux.sv
// Combinational N_SRC-way select of {valid, hi, lo} from the packed source buses.
module hilo_src_mux
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_SRC = 2,
    parameter int SEL_W = sel_w(N_SRC)
) (
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC*WIDTH-1:0] src_hi,
    input  logic [N_SRC*WIDTH-1:0] src_lo,
    output logic                   valid,
    output logic [WIDTH-1:0]       hi,
    output logic [WIDTH-1:0]       lo
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        valid = 1'b0;
        hi    = '0;
        lo    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                valid = src_valid[i];
                hi    = src_hi[i*WIDTH +: WIDTH];
                lo    = src_lo[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner: waits on the selected mult/div source and captures its result.
// Optional multiply-accumulate capture is enabled by defining HILO_MADD_EN.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_SRC = 2,
    parameter int SEL_W = sel_w(N_SRC)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   md_start,
    input  logic [SEL_W-1:0]       md_sel,
    input  logic                   md_acc,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC*WIDTH-1:0] src_hi,
    input  logic [N_SRC*WIDTH-1:0] src_lo,
    input  logic                   mthi_we,
    input  logic                   mtlo_we,
    input  logic [WIDTH-1:0]       mt_data,
    output logic [WIDTH-1:0]       hi_out,
    output logic [WIDTH-1:0]       lo_out,
    output logic                   busy,
    output logic                   done,
    output logic                   sel_err
);

    hilo_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q;
    logic             acc_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, sel_err_q;

    logic             mux_valid;
    logic [WIDTH-1:0] mux_hi, mux_lo;
    logic [WIDTH-1:0] cap_hi, cap_lo;
    logic             sel_ok, accept, capture, mt_en, sel_err_d;

    hilo_src_mux #(
        .WIDTH (WIDTH),
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_src_mux (
        .sel       (sel_q),
        .src_valid (src_valid),
        .src_hi    (src_hi),
        .src_lo    (src_lo),
        .valid     (mux_valid),
        .hi        (mux_hi),
        .lo        (mux_lo)
    );

    // Widen before comparing so non-power-of-two source counts are range-checked.
    assign sel_ok = (32'(md_sel) < N_SRC);

`ifdef HILO_MADD_EN
    logic [2*WIDTH-1:0] madd_sum;
    assign madd_sum = {hi_q, lo_q} + {mux_hi, mux_lo};
    assign cap_hi   = acc_q ? madd_sum[2*WIDTH-1:WIDTH] : mux_hi;
    assign cap_lo   = acc_q ? madd_sum[WIDTH-1:0]       : mux_lo;
`else
    logic unused_acc;
    assign unused_acc = acc_q;
    assign cap_hi     = mux_hi;
    assign cap_lo     = mux_lo;
`endif

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        mt_en     = 1'b0;
        sel_err_d = 1'b0;
        case (state_q)
            HILO_IDLE: begin
                mt_en = 1'b1;
                if (md_start) begin
                    if (sel_ok) begin
                        accept  = 1'b1;
                        state_d = HILO_WAIT;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            HILO_WAIT: begin
                if (mux_valid) begin
                    capture = 1'b1;
                    state_d = HILO_IDLE;
                end
            end
            default: state_d = HILO_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HILO_IDLE;
            sel_q     <= '0;
            acc_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            done_q    <= capture;
            sel_err_q <= sel_err_d;
            if (accept) begin
                sel_q <= md_sel;
                acc_q <= md_acc;
            end
            if (capture) begin
                hi_q <= cap_hi;
                lo_q <= cap_lo;
            end else if (mt_en) begin
                if (mthi_we) hi_q <= mt_data;
                if (mtlo_we) lo_q <= mt_data;
            end
        end
    end

    assign hi_out  = hi_q;
    assign lo_out  = lo_q;
    assign busy    = (state_q == HILO_WAIT);
    assign done    = done_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit (N_SRC=3): driver pushes expected events, monitor pops on done/sel_err.
module tb_hilo_unit;

    localparam int WIDTH = 32;
    localparam int N_SRC = 3;
    localparam int SEL_W = 2;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   md_start = 1'b0;
    logic [SEL_W-1:0]       md_sel = '0;
    logic                   md_acc = 1'b0;
    logic [N_SRC-1:0]       src_valid = '0;
    logic [N_SRC*WIDTH-1:0] src_hi = '0;
    logic [N_SRC*WIDTH-1:0] src_lo = '0;
    logic                   mthi_we = 1'b0;
    logic                   mtlo_we = 1'b0;
    logic [WIDTH-1:0]       mt_data = '0;
    logic [WIDTH-1:0]       hi_out, lo_out;
    logic                   busy, done, sel_err;

    typedef struct {
        bit               is_err;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] hi_m = '0;
    logic [WIDTH-1:0] lo_m = '0;

    hilo_unit #(
        .WIDTH (WIDTH),
        .N_SRC (N_SRC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .md_start  (md_start),
        .md_sel    (md_sel),
        .md_acc    (md_acc),
        .src_valid (src_valid),
        .src_hi    (src_hi),
        .src_lo    (src_lo),
        .mthi_we   (mthi_we),
        .mtlo_we   (mtlo_we),
        .mt_data   (mt_data),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy),
        .done      (done),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: captured {HI,LO} as 64-bit arithmetic on the architectural registers.
    function automatic logic [2*WIDTH-1:0] model_cap(input bit acc, input logic [WIDTH-1:0] h,
                                                     input logic [WIDTH-1:0] l);
`ifdef HILO_MADD_EN
        if (acc) return {hi_m, lo_m} + {h, l};
`endif
        return {h, l};
    endfunction

    always @(negedge clk) begin
        if (reset_n && (done || sel_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {62'd0, done, sel_err}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event_kind", {63'd0, sel_err}, {63'd0, mon_e.is_err});
                check("event_both", {63'd0, done & sel_err}, 64'd0);
                check("event_hi", hi_out, mon_e.hi);
                check("event_lo", lo_out, mon_e.lo);
            end
        end
    end

    task automatic do_mt(input bit hw, input bit lw, input logic [WIDTH-1:0] data);
        mthi_we = hw;
        mtlo_we = lw;
        mt_data = data;
        step();
        if (hw) hi_m = data;
        if (lw) lo_m = data;
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        check("mt_hi", hi_out, hi_m);
        check("mt_lo", lo_out, lo_m);
    endtask

    task automatic do_err();
        md_start = 1'b1;
        md_sel   = 2'd3;
        md_acc   = 1'($urandom_range(0, 1));
        sb.push_back('{1'b1, hi_m, lo_m});
        step();
        md_start = 1'b0;
        check("err_busy", busy, 0);
    endtask

    task automatic do_op(input int sel, input bit acc, input int gap,
                         input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l,
                         input bit start_valid, input bit junk, input bit mt_start,
                         input bit mt_wait, input bit wait_start);
        logic [2*WIDTH-1:0] cap;
        int                 busy_cnt;
        busy_cnt = 0;
        md_start = 1'b1;
        md_sel   = SEL_W'(sel);
        md_acc   = acc;
        if (mt_start) begin
            mthi_we = 1'($urandom_range(0, 1));
            mtlo_we = 1'($urandom_range(0, 1));
            mt_data = $urandom;
        end
        if (start_valid) begin
            src_valid[sel]              = 1'b1;
            src_hi[sel*WIDTH +: WIDTH] = $urandom;
            src_lo[sel*WIDTH +: WIDTH] = $urandom;
        end
        step();
        if (mthi_we) hi_m = mt_data;
        if (mtlo_we) lo_m = mt_data;
        md_start  = 1'b0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        src_valid = '0;
        check("start_hi", hi_out, hi_m);
        check("start_lo", lo_out, lo_m);
        for (int g = 0; g < gap; g++) begin
            if (busy) busy_cnt++;
            if (junk) begin
                for (int j = 0; j < N_SRC; j++) begin
                    if (j != sel) begin
                        src_valid[j]              = 1'b1;
                        src_hi[j*WIDTH +: WIDTH] = $urandom;
                        src_lo[j*WIDTH +: WIDTH] = $urandom;
                    end
                end
            end
            if (mt_wait && g == 0) begin
                mthi_we = 1'b1;
                mtlo_we = 1'b1;
                mt_data = $urandom;
            end
            if (wait_start && g == gap - 1) begin
                md_start = 1'b1;
                md_sel   = SEL_W'($urandom_range(0, 3));
            end
            step();
            md_start  = 1'b0;
            mthi_we   = 1'b0;
            mtlo_we   = 1'b0;
            src_valid = '0;
            check("wait_hold_hi", hi_out, hi_m);
            check("wait_hold_lo", lo_out, lo_m);
        end
        if (busy) busy_cnt++;
        src_valid[sel]              = 1'b1;
        src_hi[sel*WIDTH +: WIDTH] = h;
        src_lo[sel*WIDTH +: WIDTH] = l;
        cap = model_cap(acc, h, l);
        sb.push_back('{1'b0, cap[2*WIDTH-1:WIDTH], cap[WIDTH-1:0]});
        step();
        hi_m      = cap[2*WIDTH-1:WIDTH];
        lo_m      = cap[WIDTH-1:0];
        src_valid = '0;
        check("busy_cycles", 64'(busy_cnt), 64'(gap + 1));
        check("busy_after_capture", busy, 0);
    endtask

    initial begin
        step();
        step();
        check("reset_hi", hi_out, 0);
        check("reset_lo", lo_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sel_err", sel_err, 0);
        reset_n = 1'b1;
        step();

        do_op(0, 1'b0, 3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_hi", hi_out, 32'hDEAD_BEEF);
        check("t2_lo", lo_out, 32'h1234_5678);

        do_op(1, 1'b0, 2, 32'd7, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_hi", hi_out, 32'd7);
        check("t3_lo", lo_out, 32'd3);

        do_err();
        step();

        do_mt(1'b1, 1'b1, 32'hA5A5_0001);
        check("t5_hi", hi_out, 32'hA5A5_0001);
        check("t5_lo", lo_out, 32'hA5A5_0001);
        do_op(2, 1'b0, 2, $urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        do_mt(1'b1, 1'b0, 32'd0);
        do_mt(1'b0, 1'b1, 32'hFFFF_FFFF);
        do_op(0, 1'b1, 1, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HILO_MADD_EN
        check("t6a_hi", hi_out, 32'd1);
        check("t6a_lo", lo_out, 32'd0);
`else
        check("t6a_hi", hi_out, 32'd0);
        check("t6a_lo", lo_out, 32'd1);
`endif
        do_mt(1'b1, 1'b1, 32'hFFFF_FFFF);
        do_op(1, 1'b1, 0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HILO_MADD_EN
        check("t6b_hi", hi_out, 32'd0);
        check("t6b_lo", lo_out, 32'd0);
`else
        check("t6b_hi", hi_out, 32'd0);
        check("t6b_lo", lo_out, 32'd1);
`endif

        // Abort an op with reset while the selected source is presenting a result.
        do_mt(1'b1, 1'b1, 32'h0BAD_F00D);
        md_start = 1'b1;
        md_sel   = 2'd0;
        step();
        md_start = 1'b0;
        step();
        src_valid[0]        = 1'b1;
        src_hi[WIDTH-1:0]   = 32'h1111_2222;
        src_lo[WIDTH-1:0]   = 32'h3333_4444;
        #2 reset_n = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        check("t1_hi", hi_out, 0);
        check("t1_lo", lo_out, 0);
        check("t1_busy", busy, 0);
        check("t1_done", done, 0);
        step();
        src_valid = '0;
        step();
        reset_n = 1'b1;
        step();
        check("t1_post_busy", busy, 0);
        check("t1_post_done", done, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       do_err();
                1:       do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                default: do_op(int'($urandom_range(0, N_SRC - 1)), 1'($urandom_range(0, 1)),
                               int'($urandom_range(0, 4)), $urandom, $urandom,
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
            endcase
            if ($urandom_range(0, 3) == 0) step();
        end

        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        step();
        check("scoreboard_drain", 64'(sb.size()), 64'd0);
        check("final_hi", hi_out, hi_m);
        check("final_lo", lo_out, lo_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
